// File: rtl/nibble_deserializer.sv
// nibble_deserializer: rebuilds an MSG_SIZE-bit word from a stream of
// 4-bit nibbles, first nibble = most-significant nibble.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   open a new frame (drops any partial assembly)
//   in_valid   in   in_nibble valid this cycle
//   in_nibble  in   4-bit data, MSB nibble first
//   msg_out    out  last completed word, held until next completion
//   msg_valid  out  one-cycle pulse when msg_out updates
//   busy       out  frame open (COLLECT)
//   nib_count  out  nibbles accepted in the current frame
//   frame_err  out  one-cycle pulse when start aborts a partial frame
module nibble_deserializer #(
    parameter int MSG_SIZE = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [3:0]                       in_nibble,
    output logic [MSG_SIZE-1:0]              msg_out,
    output logic                             msg_valid,
    output logic                             busy,
    output logic [$clog2(MSG_SIZE/4):0]      nib_count,
    output logic                             frame_err
);

    localparam int NIBBLES = MSG_SIZE / 4;
    localparam int CW      = $clog2(NIBBLES) + 1;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [MSG_SIZE-1:0] asm_q, asm_d;
    logic [MSG_SIZE-1:0] msg_q, msg_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic                in_frame;
    logic                last_nib;
    logic [MSG_SIZE-1:0] shifted;

    assign in_frame = (state_q == COLLECT);
    assign last_nib = in_frame && in_valid && (cnt_q == CW'(NIBBLES - 1));
    assign shifted  = {asm_q[MSG_SIZE-5:0], in_nibble};

    always_comb begin
        state_d = state_q;
        asm_d   = asm_q;
        msg_d   = msg_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        if (last_nib) begin
            // The final nibble always belongs to the open frame; a
            // coincident start only opens a fresh, empty frame.
            msg_d   = shifted;
            valid_d = 1'b1;
            asm_d   = '0;
            cnt_d   = '0;
            state_d = start ? COLLECT : IDLE;
        end else if (start) begin
            err_d   = in_frame && (cnt_q != '0);
            state_d = COLLECT;
            if (in_valid) begin
                asm_d = {{(MSG_SIZE-4){1'b0}}, in_nibble};
                cnt_d = CW'(1);
            end else begin
                asm_d = '0;
                cnt_d = '0;
            end
        end else if (in_frame && in_valid) begin
            asm_d = shifted;
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            asm_q   <= '0;
            msg_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            msg_q   <= msg_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign msg_out   = msg_q;
    assign msg_valid = valid_q;
    assign busy      = in_frame;
    assign nib_count = cnt_q;
    assign frame_err = err_q;

endmodule

// File: tb/tb_nibble_deserializer.sv
// Testbench for nibble_deserializer: table-driven 16-bit vectors plus a
// 32-bit loopback against a shifter model.
module tb_nibble_deserializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_nibble = 4'h0;

    logic [15:0] m16;
    logic        v16, b16, e16;
    logic [2:0]  c16;
    logic [31:0] m32;
    logic        v32, b32, e32;
    logic [3:0]  c32;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nibble_deserializer #(.MSG_SIZE(16)) u16 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_nibble(in_nibble), .msg_out(m16), .msg_valid(v16),
        .busy(b16), .nib_count(c16), .frame_err(e16)
    );

    nibble_deserializer #(.MSG_SIZE(32)) u32 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_nibble(in_nibble), .msg_out(m32), .msg_valid(v32),
        .busy(b32), .nib_count(c32), .frame_err(e32)
    );

    typedef struct {
        logic        rst;
        logic        start;
        logic        iv;
        logic [3:0]  nib;
        logic        ev;
        logic        eb;
        logic [2:0]  ec;
        logic        ee;
        logic [15:0] em;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic s, input logic iv,
                       input logic [3:0] n, input logic ev, input logic eb,
                       input logic [2:0] ec, input logic ee,
                       input logic [15:0] em);
        vec_t v;
        v.rst = r; v.start = s; v.iv = iv; v.nib = n;
        v.ev = ev; v.eb = eb; v.ec = ec; v.ee = ee; v.em = em;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic iv,
                         input logic [3:0] n);
        @(negedge clk);
        rst = r; start = s; in_valid = iv; in_nibble = n;
        @(posedge clk);
        #1;
    endtask

    logic [31:0] word;

    initial begin
        // rst st iv nib  v  b  cnt err msg
        add(1, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
        // consecutive nibbles A B C D
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 16'h0000);
        add(0, 0, 1, 4'hA, 0, 1, 1, 0, 16'h0000);
        add(0, 0, 1, 4'hB, 0, 1, 2, 0, 16'h0000);
        add(0, 0, 1, 4'hC, 0, 1, 3, 0, 16'h0000);
        add(0, 0, 1, 4'hD, 1, 0, 0, 0, 16'hABCD);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 16'hABCD);
        // start+valid, then a 5-cycle gap
        add(0, 1, 1, 4'h1, 0, 1, 1, 0, 16'hABCD);
        add(0, 0, 1, 4'h2, 0, 1, 2, 0, 16'hABCD);
        for (int i = 0; i < 5; i++)
            add(0, 0, 0, 4'h7, 0, 1, 2, 0, 16'hABCD);
        add(0, 0, 1, 4'h3, 0, 1, 3, 0, 16'hABCD);
        add(0, 0, 1, 4'h4, 1, 0, 0, 0, 16'h1234);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 16'h1234);
        // restart aborts partial frame
        add(1, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 16'h0000);
        add(0, 0, 1, 4'h5, 0, 1, 1, 0, 16'h0000);
        add(0, 0, 1, 4'h6, 0, 1, 2, 0, 16'h0000);
        add(0, 1, 0, 4'h0, 0, 1, 0, 1, 16'h0000);
        add(0, 0, 1, 4'h7, 0, 1, 1, 0, 16'h0000);
        add(0, 0, 1, 4'h8, 0, 1, 2, 0, 16'h0000);
        add(0, 0, 1, 4'h9, 0, 1, 3, 0, 16'h0000);
        add(0, 0, 1, 4'hA, 1, 0, 0, 0, 16'h789A);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 16'h789A);
        // valid while idle is ignored
        add(0, 0, 1, 4'hF, 0, 0, 0, 0, 16'h789A);
        add(0, 0, 1, 4'hF, 0, 0, 0, 0, 16'h789A);
        // reset mid-frame drops it silently
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 16'h789A);
        add(0, 0, 1, 4'h1, 0, 1, 1, 0, 16'h789A);
        add(0, 0, 1, 4'h2, 0, 1, 2, 0, 16'h789A);
        add(0, 0, 1, 4'h3, 0, 1, 3, 0, 16'h789A);
        add(1, 0, 0, 4'h0, 0, 0, 0, 0, 16'h0000);
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 16'h0000);
        add(0, 0, 1, 4'hC, 0, 1, 1, 0, 16'h0000);
        add(0, 0, 1, 4'hA, 0, 1, 2, 0, 16'h0000);
        add(0, 0, 1, 4'hF, 0, 1, 3, 0, 16'h0000);
        add(0, 0, 1, 4'hE, 1, 0, 0, 0, 16'hCAFE);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 16'hCAFE);
        // start on an empty open frame: no error
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 16'hCAFE);
        add(0, 1, 0, 4'h0, 0, 1, 0, 0, 16'hCAFE);
        // start+valid on partial frame: error, nibble is new nibble 0
        add(0, 0, 1, 4'h1, 0, 1, 1, 0, 16'hCAFE);
        add(0, 1, 1, 4'h2, 0, 1, 1, 1, 16'hCAFE);
        add(0, 0, 1, 4'h3, 0, 1, 2, 0, 16'hCAFE);
        add(0, 0, 1, 4'h4, 0, 1, 3, 0, 16'hCAFE);
        add(0, 0, 1, 4'h5, 1, 0, 0, 0, 16'h2345);
        add(0, 0, 0, 4'h0, 0, 0, 0, 0, 16'h2345);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].iv, vecs[i].nib);
            chk("msg_valid", i, {31'd0, v16}, {31'd0, vecs[i].ev});
            chk("busy", i, {31'd0, b16}, {31'd0, vecs[i].eb});
            chk("nib_count", i, {29'd0, c16}, {29'd0, vecs[i].ec});
            chk("frame_err", i, {31'd0, e16}, {31'd0, vecs[i].ee});
            chk("msg_out", i, {16'd0, m16}, {16'd0, vecs[i].em});
        end

        // 32-bit loopback of a shifter loaded with DEADBEEF, with start
        // coinciding with the last nibble.
        word = 32'hDEADBEEF;
        drive(1, 0, 0, 4'h0);
        chk("rst32_msg", 0, m32, 32'h0);
        drive(0, 1, 0, 4'h0);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 1, word[31 - 4*i -: 4]);
            chk("lb_cnt", i, {28'd0, c32}, 32'(i + 1));
            chk("lb_valid", i, {31'd0, v32}, 32'd0);
        end
        drive(0, 1, 1, word[3:0]);
        chk("lb_msg", 7, m32, 32'hDEADBEEF);
        chk("lb_valid", 7, {31'd0, v32}, 32'd1);
        chk("lb_busy", 7, {31'd0, b32}, 32'd1);
        chk("lb_cnt", 7, {28'd0, c32}, 32'd0);
        chk("lb_err", 7, {31'd0, e32}, 32'd0);

        // the frame opened above collects a second word
        word = 32'h0123_4567;
        for (int i = 0; i < 8; i++)
            drive(0, 0, 1, word[31 - 4*i -: 4]);
        chk("lb2_msg", 8, m32, 32'h0123_4567);
        chk("lb2_valid", 8, {31'd0, v32}, 32'd1);
        chk("lb2_busy", 8, {31'd0, b32}, 32'd0);
        drive(0, 0, 0, 4'h0);
        chk("lb2_pulse", 9, {31'd0, v32}, 32'd0);
        chk("lb2_hold", 9, m32, 32'h0123_4567);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
